// File: rtl/vga_pkg.sv
// Shared types and constants for the raster timing path: standard mode timings,
// colour-bar table and line/frame total helpers.
package vga_pkg;

    typedef struct packed {
        int h_sync;
        int h_back;
        int h_disp;
        int h_front;
        int v_sync;
        int v_back;
        int v_disp;
        int v_front;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60  = '{96, 48, 640, 16, 2, 33, 480, 10};
    localparam vga_mode_t MODE_800X600_60  = '{128, 88, 800, 40, 4, 23, 600, 1};
    localparam vga_mode_t MODE_1280X720_60 = '{40, 220, 1280, 110, 5, 20, 720, 5};

    // RGB565: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [15:0] BAR_LUT [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_PEND = 1'b1
    } frame_state_t;

    function automatic int h_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

    function automatic int v_total(input int sync, input int back, input int disp, input int front);
        return sync + back + disp + front;
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Horizontal/vertical raster counters; also reused by the capture-side timing checker.
module vga_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525,
    parameter int CNT_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + ONE;
        end else begin
            hcnt <= hcnt + ONE;
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing generator and pixel output stage (FIFO strobes, frame request, cursor, underflow).
// Build option VGA_PATTERN_EN adds pattern_sel and an 8-bar colour test pattern.
//
// fr_state | meaning
// FR_IDLE  | no frame read outstanding
// FR_PEND  | frame_req raised, waiting for frame_ack
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0,
    parameter int PIX_W    = 16,
    parameter int CNT_W    = 12,
    parameter int REQ_LEAD = 2,
    parameter int CUR_W    = 5,
    parameter int CUR_H    = 5,
    parameter logic [PIX_W-1:0] CUR_COLOR = PIX_W'('hFFFF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] pix_data,
    input  logic             pix_empty,
    output logic             pix_req,
    output logic             frame_req,
    input  logic             frame_ack,
    input  logic [CNT_W-1:0] cursor_x,
    input  logic [CNT_W-1:0] cursor_y,
`ifdef VGA_PATTERN_EN
    input  logic             pattern_sel,
`endif
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             de,
    output logic             hsync,
    output logic             vsync,
    output logic [PIX_W-1:0] rgb,
    output logic             underflow
);

    localparam int H_TOTAL = h_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
    localparam int V_TOTAL = v_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] HA_S   = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HA_E   = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] VA_S   = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VA_E   = CNT_W'(V_SYNC + V_BACK + V_DISP);
    localparam logic [CNT_W-1:0] RQ_S   = CNT_W'(H_SYNC + H_BACK - REQ_LEAD);
    localparam logic [CNT_W-1:0] RQ_E   = CNT_W'(H_SYNC + H_BACK + H_DISP - REQ_LEAD);

    logic [CNT_W-1:0] hcnt, vcnt;
    logic [CNT_W-1:0] ax, ay;
    logic [CNT_W:0]   cx_last, cy_last;
    logic             hact, vact, act, in_box, frame_set;
    logic [PIX_W-1:0] pix_val;
    frame_state_t     fr_state, fr_next;

    vga_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL),
        .CNT_W   (CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .hcnt (hcnt),
        .vcnt (vcnt)
    );

    assign hact = (hcnt >= HA_S) && (hcnt < HA_E);
    assign vact = (vcnt >= VA_S) && (vcnt < VA_E);
    assign act  = en && hact && vact;
    assign ax   = hcnt - HA_S;
    assign ay   = vcnt - VA_S;

    // Strobe window is the active window shifted early by the FIFO read latency.
    assign pix_req = en && !rst && vact && (hcnt >= RQ_S) && (hcnt < RQ_E);

    // One extra bit keeps a box at the far edge from wrapping onto column/row 0.
    assign cx_last = {1'b0, cursor_x} + (CNT_W+1)'(CUR_W - 1);
    assign cy_last = {1'b0, cursor_y} + (CNT_W+1)'(CUR_H - 1);
    assign in_box  = (ax >= cursor_x) && ({1'b0, ax} <= cx_last) &&
                     (ay >= cursor_y) && ({1'b0, ay} <= cy_last);

`ifdef VGA_PATTERN_EN
    localparam int BAR_W = (H_DISP / 8 > 0) ? H_DISP / 8 : 1;
    logic [CNT_W-1:0] bar_q;
    logic [2:0]       bar_idx;

    assign bar_q   = ax / CNT_W'(BAR_W);
    assign bar_idx = (bar_q > CNT_W'(7)) ? 3'd7 : bar_q[2:0];
`endif

    always_comb begin
        pix_val = pix_data;
`ifdef VGA_PATTERN_EN
        if (pattern_sel) begin
            pix_val = PIX_W'(BAR_LUT[bar_idx]);
        end
`endif
        if (in_box) begin
            pix_val = CUR_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            rgb   <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else begin
            de    <= act;
            x     <= act ? ax : '0;
            y     <= act ? ay : '0;
            rgb   <= act ? pix_val : '0;
            hsync <= (hcnt < HS_END) ? HS_POL : ~HS_POL;
            vsync <= (vcnt < VS_END) ? VS_POL : ~VS_POL;
        end
    end

    assign frame_set = en && (hcnt == '0) && (vcnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fr_state <= FR_IDLE;
        end else begin
            fr_state <= fr_next;
        end
    end

    always_comb begin
        fr_next = fr_state;
        case (fr_state)
            FR_IDLE: if (frame_set) fr_next = FR_PEND;
            FR_PEND: if (frame_ack && !frame_set) fr_next = FR_IDLE;
            default: fr_next = FR_IDLE;
        endcase
    end

    assign frame_req = (fr_state == FR_PEND);

    // Cleared at each frame start so the flag reports on the previous frame only.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (frame_set) begin
            underflow <= 1'b0;
        end else if (pix_req && pix_empty) begin
            underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl in a 16x7 raster mode with a latency-2 FIFO model.
module tb_vga_timing_ctrl;

    localparam logic [15:0] BASE = 16'h0100;
    localparam logic [15:0] CUR  = 16'hFFFF;
    localparam logic [63:0] RST_OUTS = {18'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        pix_empty = 1'b0;
    logic        frame_ack = 1'b0;
    logic [15:0] pix_data = 16'h0;
    logic [11:0] cursor_x = 12'd100;
    logic [11:0] cursor_y = 12'd100;
    logic        pix_req, frame_req, de, hsync, vsync, underflow;
    logic [11:0] x, y;
    logic [15:0] rgb;

    vga_timing_ctrl #(
        .H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1),
        .PIX_W(16), .CNT_W(12), .REQ_LEAD(2), .CUR_W(2), .CUR_H(2),
        .CUR_COLOR(16'hFFFF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .pix_data(pix_data), .pix_empty(pix_empty), .pix_req(pix_req),
        .frame_req(frame_req), .frame_ack(frame_ack),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        pr, de, hs, vs;
        logic [11:0] x, y;
        logic [15:0] rgb;
    } vec_t;

    vec_t        vt[16];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        q1_v = 1'b0, q2_v = 1'b0;
    logic [15:0] q1_d = 16'h0, q2_d = 16'h0;
    int          next_word = 0;
    int          hs_lo, de_hi, cnt, lat;
    int          pr_f[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {18'd0, pix_req, frame_req, underflow, de, hsync, vsync, x, y, rgb};
    endfunction

    // FIFO model: word requested on a strobe appears on pix_data two clocks later.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pix_data = q2_v ? q2_d : 16'h0;
        q2_v = q1_v;
        q2_d = q1_d;
        q1_v = pix_req;
        q1_d = BASE + 16'(next_word);
        if (pix_req) next_word++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        q1_v = 1'b0;
        q2_v = 1'b0;
        next_word = 0;
        pix_data = 16'h0;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic run_frame(input int cx, input int cy, input int exp_cur, input string tag);
        int k, ncur, ex, ey;
        logic inb;
        logic [15:0] er;
        cursor_x = 12'(cx);
        cursor_y = 12'(cy);
        do_reset();
        k = 0;
        ncur = 0;
        for (int i = 0; i < 113; i++) begin
            tick();
            if (de) begin
                ex = k % 8;
                ey = k / 8;
                inb = (ex >= cx) && (ex <= cx + 1) && (ey >= cy) && (ey <= cy + 1);
                er = inb ? CUR : BASE + 16'(k);
                if (rgb == CUR) ncur++;
                chk($sformatf("%s_px%0d", tag, k), {24'd0, x, y, rgb}, {24'd0, 12'(ex), 12'(ey), er});
                k++;
            end
        end
        chk($sformatf("%s_npix", tag), 64'(k), 64'd32);
        chk($sformatf("%s_ncur", tag), 64'(ncur), 64'(exp_cur));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //             n    pr    de    hs    vs    x      y      rgb
        vt[0]  = '{  1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'h0000};
        vt[1]  = '{  4, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'h0000};
        vt[2]  = '{  5, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 16'h0000};
        vt[3]  = '{ 16, 1'b0, 1'b0, 1'b1, 1'b0, 12'd0, 12'd0, 16'h0000};
        vt[4]  = '{ 17, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[5]  = '{ 35, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[6]  = '{ 36, 1'b1, 1'b0, 1'b0, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[7]  = '{ 38, 1'b1, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[8]  = '{ 39, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 12'd0, 16'h0100};
        vt[9]  = '{ 44, 1'b0, 1'b1, 1'b1, 1'b1, 12'd5, 12'd0, 16'h0105};
        vt[10] = '{ 46, 1'b0, 1'b1, 1'b1, 1'b1, 12'd7, 12'd0, 16'h0107};
        vt[11] = '{ 47, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[12] = '{ 88, 1'b1, 1'b1, 1'b1, 1'b1, 12'd1, 12'd3, 16'h0119};
        vt[13] = '{103, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[14] = '{112, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'h0000};
        vt[15] = '{113, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 16'h0000};

        // Reset state while rst is held
        tick();
        tick();
        chk("reset_state", outs(), RST_OUTS);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_to(vt[i].n);
            chk($sformatf("vec%0d_n%0d", i, vt[i].n),
                {20'd0, pix_req, de, hsync, vsync, x, y, rgb},
                {20'd0, vt[i].pr, vt[i].de, vt[i].hs, vt[i].vs, vt[i].x, vt[i].y, vt[i].rgb});
        end

        // Three free-running frames
        do_reset();
        hs_lo = 0;
        de_hi = 0;
        pr_f = '{0, 0, 0};
        for (int i = 1; i <= 336; i++) begin
            tick();
            if (!hsync) hs_lo++;
            if (de) de_hi++;
            if (pix_req) pr_f[(cyc - 1) / 112]++;
        end
        chk("hsync_low_clocks", 64'(hs_lo), 64'd84);
        chk("de_high_clocks", 64'(de_hi), 64'd96);
        for (int f = 0; f < 3; f++) chk($sformatf("pix_req_frame%0d", f), 64'(pr_f[f]), 64'd32);

        // Ramp and cursor placement
        run_frame(100, 100, 0, "ramp");
        run_frame(7, 3, 1, "cur_7_3");
        run_frame(0, 0, 4, "cur_0_0");
        cursor_x = 12'd100;
        cursor_y = 12'd100;

        // frame_req handshake
        do_reset();
        chk("frreq_after_rst", 64'(frame_req), 64'd0);
        tick();
        chk("frreq_set", 64'(frame_req), 64'd1);
        run_to(50);
        chk("frreq_hold_noack", 64'(frame_req), 64'd1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("frreq_drop_after_ack", 64'(frame_req), 64'd0);
        run_to(112);
        chk("frreq_idle", 64'(frame_req), 64'd0);
        tick();
        chk("frreq_reset_next_frame", 64'(frame_req), 64'd1);
        run_to(224);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("frreq_set_beats_ack", 64'(frame_req), 64'd1);
        tick();
        chk("frreq_still_high", 64'(frame_req), 64'd1);

        // Underflow stickiness and per-frame clear
        do_reset();
        run_to(35);
        pix_empty = 1'b1;
        tick();
        chk("ufl_empty_no_req", 64'(underflow), 64'd0);
        tick();
        pix_empty = 1'b0;
        chk("ufl_set", 64'(underflow), 64'd1);
        run_to(112);
        chk("ufl_sticky", 64'(underflow), 64'd1);
        tick();
        chk("ufl_clear_frame", 64'(underflow), 64'd0);
        run_to(148);
        pix_empty = 1'b1;
        tick();
        pix_empty = 1'b0;
        chk("ufl_set2", 64'(underflow), 64'd1);

        // Reset mid-line
        run_to(152);
        chk("pre_rst_de", 64'(de), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_line_rst", outs(), RST_OUTS);
        rst = 1'b0;
        cyc = 0;
        cnt = 0;
        for (int i = 1; i <= 35; i++) begin
            tick();
            if (pix_req) cnt++;
        end
        chk("post_rst_no_partial", 64'(cnt), 64'd0);
        tick();
        chk("post_rst_first_req", 64'(pix_req), 64'd1);

        // Enable dropped mid-frame
        do_reset();
        run_to(50);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("en0_clk%0d", i),
                {20'd0, pix_req, de, hsync, vsync, x, y, rgb},
                {20'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0, 12'd0, 16'd0});
        end
        en = 1'b1;
        lat = 0;
        while (!pix_req && lat < 200) begin
            tick();
            lat++;
        end
        chk("en_restart_latency", 64'(lat), 64'd36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
